ssd_scan_ctrl: RTL and testbench
================================

// Module: ssd_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a NUM_DIGITS common-anode seven-segment display.
//  Holds a frame of BCD digits and selects one digit per refresh slot.
//  Decodes that digit to active-low segments, applying leading-zero blanking and decimal points.
//  Sits between the counter/datapath logic and the board SSD pins.
// PARAMETERS
//  NUM_DIGITS   4       digits scanned; digit 0 = least significant (rightmost)
//  REFRESH_DIV  100000  clk cycles per digit slot (>=2)
//  CNT_W        17      refresh counter width; $clog2(REFRESH_DIV)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst        in   1              synchronous, active-high reset
//  load       in   1              1-cycle strobe: capture bcd_in/dp_in into pending frame
//  bcd_in     in   4*NUM_DIGITS   digit i = bcd_in[4i+3:4i]
//  dp_in      in   NUM_DIGITS     decimal point request per digit, 1 = lit
//  blank_lz   in   1              1 = blank leading zeros (level, sampled each slot)
//  ssd_ctl    out  NUM_DIGITS     digit enables, active-low, one-cold
//  segs       out  8              {a,b,c,d,e,f,g,dp}, active-low
//  frame_done out  1              1-cycle pulse when digit NUM_DIGITS-1 slot ends
// BEHAVIOUR
//  Reset (rst=1 at edge): ssd_ctl=all 1s, segs=8'hFF, frame_done=0, cnt=0, idx=0,
//   active frame=0 (all digits 0, no dp), pending_v=0. rst dominates all inputs.
//  Refresh: cnt counts 0..REFRESH_DIV-1; tick when cnt==REFRESH_DIV-1; cnt wraps to 0.
//   On tick idx increments; idx==NUM_DIGITS-1 wraps to 0 and sets frame_done for that cycle.
//  Output latency: ssd_ctl/segs are registered and reflect idx one cycle after idx changes.
//   The first scanned digit after reset is digit 0, driven from the cycle after rst deasserts.
//  Frame update (tear-free): load writes pending regs and sets pending_v. Active frame only
//   changes on a wrapping tick (idx NUM_DIGITS-1 -> 0): if pending_v, active<=pending, pending_v<=0.
//   load during a pending frame overwrites pending (last write wins).
//   load on the same cycle as a wrapping tick: bcd_in/dp_in go straight to active, pending_v<=0.
//  Decode (active-low, dp bit = segs[0]): 0=0000_0011 1=1001_1111 2=0010_0101 3=0000_1101
//   4=1001_1001 5=0100_1001 6=0100_0001 7=0001_1111 8=0000_0001 9=0000_1001.
//   Codes 10..15: segments a..g all off (blank), dp still per dp_in.
//  Leading-zero blank: with blank_lz=1, digit i>0 is blanked (segs[7:1]=7'h7F) when digits
//   NUM_DIGITS-1..i are all 0. Digit 0 is never blanked. A dp on a blanked digit stays lit.
//  ssd_ctl: bit idx low, all others high. No overlap: ssd_ctl and segs update in the same cycle.
// STRUCTURE
//  Package ssd_pkg: SSD_* segment constants, SSD_BLANK=8'hFF, function ssd_decode(bcd,dp).
//  Sub-module ssd_scan_tick: cnt + tick generator (params REFRESH_DIV, CNT_W).
//  Top holds idx, pending/active frame regs, blanking logic, and output regs.
// TESTING (REFRESH_DIV=4, NUM_DIGITS=4)
//  Reset: rst high 3 cycles -> ssd_ctl=4'hF, segs=8'hFF, frame_done=0; release -> ssd_ctl=4'hE.
//  Scan: no load -> ssd_ctl sequence E,D,B,7 every 4 cycles, segs=8'h03, frame_done once per 16.
//  Load: load bcd_in=16'h1234 mid-frame -> old digits until wrap, then digit0 segs=8'h99, digit3=8'h9F.
//  Coincident: load 16'h0507 on wrapping tick -> very next digit0 slot shows 8'h1F (7).
//  Blanking: bcd_in=16'h0040, blank_lz=1 -> digits3,2 = 8'hFF, digit1=8'h99, digit0=8'h03;
//   dp_in=4'b1000 -> digit3 = 8'hFE.
//  Invalid/reset: bcd 4'hC -> 8'hFF; rst asserted mid-slot -> next cycle reset values, scan restarts at digit 0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low {a,b,c,d,e,f,g,dp} glyphs and the BCD decoder.
package ssd_pkg;

   localparam logic [7:0] SSD_0     = 8'h03;
   localparam logic [7:0] SSD_1     = 8'h9F;
   localparam logic [7:0] SSD_2     = 8'h25;
   localparam logic [7:0] SSD_3     = 8'h0D;
   localparam logic [7:0] SSD_4     = 8'h99;
   localparam logic [7:0] SSD_5     = 8'h49;
   localparam logic [7:0] SSD_6     = 8'h41;
   localparam logic [7:0] SSD_7     = 8'h1F;
   localparam logic [7:0] SSD_8     = 8'h01;
   localparam logic [7:0] SSD_9     = 8'h09;
   localparam logic [7:0] SSD_BLANK = 8'hFF;

   // Non-decimal codes light no segments; the decimal point is honoured regardless.
   function automatic logic [7:0] ssd_decode(input logic [3:0] bcd, input logic dp);
      logic [7:0] seg;
      case (bcd)
         4'd0:    seg = SSD_0;
         4'd1:    seg = SSD_1;
         4'd2:    seg = SSD_2;
         4'd3:    seg = SSD_3;
         4'd4:    seg = SSD_4;
         4'd5:    seg = SSD_5;
         4'd6:    seg = SSD_6;
         4'd7:    seg = SSD_7;
         4'd8:    seg = SSD_8;
         4'd9:    seg = SSD_9;
         default: seg = SSD_BLANK;
      endcase
      seg[0] = ~dp;
      return seg;
   endfunction

endpackage

// File: rtl/ssd_scan_tick.sv
// Refresh-slot timer: one-cycle tick every REFRESH_DIV clocks.
module ssd_scan_tick #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed common-anode SSD scanner with tear-free frame update and leading-zero blanking.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   ssd_ctl,
   output logic [7:0]              segs,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic                    tick;
   logic                    wrap;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] act_bcd;
   logic [4*NUM_DIGITS-1:0] pend_bcd;
   logic [NUM_DIGITS-1:0]   act_dp;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_v;
   logic [NUM_DIGITS-1:0]   lead_zero;
   logic [3:0]              dig_sel;
   logic                    blank;
   logic [7:0]              seg_next;
   logic [NUM_DIGITS-1:0]   ctl_next;

   ssd_scan_tick #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (CNT_W)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst)
         idx <= '0;
      else if (wrap)
         idx <= '0;
      else if (tick)
         idx <= idx + IDX_W'(1);
   end

   // The displayed frame only changes between scans, so a digit never shows half-old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_bcd  <= '0;
         act_dp   <= '0;
         pend_bcd <= '0;
         pend_dp  <= '0;
         pend_v   <= 1'b0;
      end else if (wrap) begin
         if (load) begin
            act_bcd <= bcd_in;
            act_dp  <= dp_in;
         end else if (pend_v) begin
            act_bcd <= pend_bcd;
            act_dp  <= pend_dp;
         end
         pend_v <= 1'b0;
      end else if (load) begin
         pend_bcd <= bcd_in;
         pend_dp  <= dp_in;
         pend_v   <= 1'b1;
      end
   end

   // lead_zero[i] is set when digit i and every more significant digit are zero.
   always_comb begin
      logic run;
      run       = 1'b1;
      lead_zero = '0;
      for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
         run          = run && (act_bcd[4*j +: 4] == 4'd0);
         lead_zero[j] = run;
      end
   end

   always_comb begin
      dig_sel  = act_bcd[4*int'(idx) +: 4];
      blank    = blank_lz && (idx != '0) && lead_zero[idx];
      seg_next = ssd_decode(dig_sel, act_dp[idx]);
      if (blank)
         seg_next[7:1] = 7'h7F;
      ctl_next = ~(NUM_DIGITS'(1) << idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ssd_ctl    <= '1;
         segs       <= SSD_BLANK;
         frame_done <= 1'b0;
      end else begin
         ssd_ctl    <= ctl_next;
         segs       <= seg_next;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl (4 digits, 4-clock slots): cycle-level reference model plus literal spot checks.
module tb_ssd_scan_ctrl;

   localparam int ND  = 4;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  ssd_ctl;
   logic [7:0]  segs;
   logic        frame_done;

   int n_chk  = 0;
   int n_fail = 0;
   int ne     = 0;
   bit check_en = 1'b0;

   ssd_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (DIV),
      .CNT_W       (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .ssd_ctl    (ssd_ctl),
      .segs       (segs),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference model: k counts clock edges since reset release; the digit shown after edge k
   // is (k / DIV) % ND, and a frame ends on the last edge of every ND*DIV-edge frame.
   logic [7:0]  seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
   int          k;
   logic [15:0] m_act_bcd, m_pend_bcd;
   logic [3:0]  m_act_dp, m_pend_dp;
   bit          m_pv;
   logic [3:0]  exp_ctl;
   logic [7:0]  exp_segs;
   logic        exp_fd;

   function automatic logic [7:0] model_seg(input logic [15:0] frame, input logic [3:0] dps,
                                            input int d, input bit blz);
      logic [3:0] v;
      logic [7:0] r;
      bit         lead;
      v    = frame[d*4 +: 4];
      lead = 1'b1;
      for (int j = d; j < ND; j++)
         if (frame[j*4 +: 4] != 4'd0) lead = 1'b0;
      r = (v < 4'd10) ? seg_tab[v] : 8'hFF;
      if (blz && d > 0 && lead) r[7:1] = 7'h7F;
      r[0] = ~dps[d];
      return r;
   endfunction

   always @(posedge clk) begin
      int  d;
      bit  wrap;
      if (rst) begin
         exp_ctl   = 4'hF;
         exp_segs  = 8'hFF;
         exp_fd    = 1'b0;
         k         = 0;
         m_act_bcd = '0;
         m_act_dp  = '0;
         m_pv      = 1'b0;
      end else begin
         d        = (k / DIV) % ND;
         wrap     = ((k % (ND*DIV)) == ND*DIV - 1);
         exp_ctl  = 4'hF;
         exp_ctl[d] = 1'b0;
         exp_segs = model_seg(m_act_bcd, m_act_dp, d, blank_lz);
         exp_fd   = wrap;
         if (wrap) begin
            if (load) begin
               m_act_bcd = bcd_in;
               m_act_dp  = dp_in;
            end else if (m_pv) begin
               m_act_bcd = m_pend_bcd;
               m_act_dp  = m_pend_dp;
            end
            m_pv = 1'b0;
         end else if (load) begin
            m_pend_bcd = bcd_in;
            m_pend_dp  = dp_in;
            m_pv       = 1'b1;
         end
         k++;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model ssd_ctl", {4'h0, ssd_ctl}, {4'h0, exp_ctl});
         check("model segs", segs, exp_segs);
         check("model frame_done", {7'h0, frame_done}, {7'h0, exp_fd});
      end
   end

   task automatic step();
      @(negedge clk);
      ne++;
   endtask

   // Advance until the outputs visible are those produced by edge kk after reset release.
   task automatic goto(input int kk);
      while (ne < kk + 1) step();
   endtask

   task automatic do_load(input int kk, input logic [15:0] b, input logic [3:0] dp);
      goto(kk - 1);
      load   = 1'b1;
      bcd_in = b;
      dp_in  = dp;
      step();
      load   = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      bcd_in   = '0;
      dp_in    = '0;
      blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      check("reset ssd_ctl", {4'h0, ssd_ctl}, 8'h0F);
      check("reset segs", segs, 8'hFF);
      check("reset frame_done", {7'h0, frame_done}, 8'h00);
      rst = 1'b0;
      ne  = 0;

      // Free-running scan with the reset frame of zeros
      goto(0);  check("scan d0 ctl", {4'h0, ssd_ctl}, 8'h0E);
                check("scan d0 segs", segs, 8'h03);
      goto(4);  check("scan d1 ctl", {4'h0, ssd_ctl}, 8'h0D);
      goto(8);  check("scan d2 ctl", {4'h0, ssd_ctl}, 8'h0B);
      goto(12); check("scan d3 ctl", {4'h0, ssd_ctl}, 8'h07);
      goto(14); check("frame_done low", {7'h0, frame_done}, 8'h00);
      goto(15); check("frame_done pulse", {7'h0, frame_done}, 8'h01);
      goto(16); check("frame_done one cycle", {7'h0, frame_done}, 8'h00);

      // Mid-frame load waits for the wrap
      do_load(18, 16'h1234, 4'h0);
      goto(28); check("old frame until wrap", segs, 8'h03);
      goto(32); check("new digit0 = 4", segs, 8'h99);
      goto(44); check("new digit3 = 1", segs, 8'h9F);

      // Load coincident with the wrapping tick goes straight to the active frame
      do_load(47, 16'h0507, 4'h0);
      goto(48); check("coincident digit0 = 7", segs, 8'h1F);

      // Last pending write wins
      do_load(51, 16'h1111, 4'h0);
      do_load(54, 16'h2222, 4'h0);
      goto(60); check("pending not yet shown", segs, 8'h03);
      goto(64); check("last write wins", segs, 8'h25);

      // Leading-zero blanking
      blank_lz = 1'b1;
      do_load(67, 16'h0040, 4'h0);
      goto(80); check("lz digit0", segs, 8'h03);
      goto(84); check("lz digit1", segs, 8'h99);
      goto(88); check("lz digit2 blank", segs, 8'hFF);
      goto(92); check("lz digit3 blank", segs, 8'hFF);
      do_load(95, 16'h0040, 4'b1000);
      goto(108); check("blanked digit3 with dp", segs, 8'hFE);

      // Invalid code
      do_load(111, 16'h000C, 4'h0);
      goto(112); check("invalid code blank", segs, 8'hFF);

      // Reset mid-slot
      goto(114);
      rst = 1'b1;
      @(negedge clk);
      check("midslot reset ssd_ctl", {4'h0, ssd_ctl}, 8'h0F);
      check("midslot reset segs", segs, 8'hFF);
      check("midslot reset frame_done", {7'h0, frame_done}, 8'h00);
      rst = 1'b0;
      ne  = 0;
      goto(0);
      check("restart digit0 ctl", {4'h0, ssd_ctl}, 8'h0E);
      check("restart frame cleared", segs, 8'h03);
      goto(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
